bp_be_issue_queue: RTL and testbench

BP_BE_ISSUE_QUEUE -- requirements
Module: bp_be_issue_queue

---
 rtl/bp_be_pkg.sv | 74 +++++++
 rtl/bp_be_issue_queue_if.sv | 25 ++
 rtl/bp_be_issue_predecode.sv | 108 ++++++++++
 rtl/bp_be_issue_queue.sv | 98 +++++++++
 tb/tb_bp_be_issue_queue.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_pkg.sv
// Backend package: configuration enum, payload widths, fetch/issue structs and
// the pre-decode layout shared by the issue queue and the hazard detector.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_unicore_cfg = 2'd1
  } bp_params_e;

  localparam int unsigned vaddr_width_gp           = 39;
  localparam int unsigned instr_width_gp           = 32;
  localparam int unsigned branch_metadata_width_gp = 16;
  localparam int unsigned reg_addr_width_gp        = 5;

  typedef struct packed {
    logic [vaddr_width_gp-1:0]           pc;
    logic [instr_width_gp-1:0]           instr;
    logic [branch_metadata_width_gp-1:0] branch_metadata;
  } bp_fe_queue_s;

  typedef struct packed {
    logic [reg_addr_width_gp-1:0] rs1_addr;
    logic [reg_addr_width_gp-1:0] rs2_addr;
    logic [reg_addr_width_gp-1:0] rs3_addr;
    logic [reg_addr_width_gp-1:0] rd_addr;
    logic irs1_v;
    logic irs2_v;
    logic frs1_v;
    logic frs2_v;
    logic frs3_v;
    logic iwb_v;
    logic fwb_v;
    logic mem_v;
    logic fence_v;
    logic csr_w_v;
    logic long_v;
  } bp_be_predecode_s;

  typedef struct packed {
    logic [vaddr_width_gp-1:0]           pc;
    logic [instr_width_gp-1:0]           instr;
    logic [branch_metadata_width_gp-1:0] branch_metadata;
    bp_be_predecode_s                    decode;
  } bp_be_issue_pkt_s;

  typedef struct packed {
    logic             v;
    bp_be_predecode_s decode;
  } bp_be_isd_status_s;

  localparam int unsigned fe_queue_width_gp   = $bits(bp_fe_queue_s);
  localparam int unsigned issue_pkt_width_gp  = $bits(bp_be_issue_pkt_s);
  localparam int unsigned isd_status_width_gp = $bits(bp_be_isd_status_s);

  // Detector must never see a stale entry's register use, so every flag is qualified.
  function automatic bp_be_isd_status_s gate_isd_status(input bp_be_predecode_s d, input logic v);
    bp_be_isd_status_s s;
    s.v              = v;
    s.decode         = d;
    s.decode.irs1_v  = d.irs1_v  & v;
    s.decode.irs2_v  = d.irs2_v  & v;
    s.decode.frs1_v  = d.frs1_v  & v;
    s.decode.frs2_v  = d.frs2_v  & v;
    s.decode.frs3_v  = d.frs3_v  & v;
    s.decode.iwb_v   = d.iwb_v   & v;
    s.decode.fwb_v   = d.fwb_v   & v;
    s.decode.mem_v   = d.mem_v   & v;
    s.decode.fence_v = d.fence_v & v;
    s.decode.csr_w_v = d.csr_w_v & v;
    s.decode.long_v  = d.long_v  & v;
    return s;
  endfunction

endpackage

// File: rtl/bp_be_issue_queue_if.sv
// Fetch-queue enqueue, issue control and issue-side outputs of the backend issue queue.
interface bp_be_issue_queue_if;
  import bp_be_pkg::*;

  logic              fe_queue_v_i;
  bp_fe_queue_s      fe_queue_i;
  logic              fe_queue_ready_o;
  logic              deq_v_i;
  logic              roll_v_i;
  logic              inc_v_i;
  logic              clr_v_i;
  logic              issue_pkt_v_o;
  bp_be_issue_pkt_s  issue_pkt_o;
  bp_be_isd_status_s isd_status_o;

  modport master (
    output fe_queue_v_i, fe_queue_i, deq_v_i, roll_v_i, inc_v_i, clr_v_i,
    input  fe_queue_ready_o, issue_pkt_v_o, issue_pkt_o, isd_status_o
  );

  modport slave (
    input  fe_queue_v_i, fe_queue_i, deq_v_i, roll_v_i, inc_v_i, clr_v_i,
    output fe_queue_ready_o, issue_pkt_v_o, issue_pkt_o, isd_status_o
  );
endinterface

// File: rtl/bp_be_issue_predecode.sv
// Combinational RV64GC pre-decode: register addresses, register-use and class flags.
module bp_be_issue_predecode
  import bp_be_pkg::*;
(
  input  logic [instr_width_gp-1:0] instr_i,
  output bp_be_predecode_s          decode_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] funct5;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign funct5 = instr_i[31:27];

  always_comb begin
    decode_o          = '0;
    decode_o.rs1_addr = instr_i[19:15];
    decode_o.rs2_addr = instr_i[24:20];
    decode_o.rs3_addr = instr_i[31:27];
    decode_o.rd_addr  = instr_i[11:7];
    case (opcode)
      7'b0110011, 7'b0111011: begin
        decode_o.irs1_v = 1'b1;
        decode_o.irs2_v = 1'b1;
        decode_o.iwb_v  = 1'b1;
        decode_o.long_v = (funct7 == 7'b0000001);
      end
      7'b0010011, 7'b0011011, 7'b1100111: begin
        decode_o.irs1_v = 1'b1;
        decode_o.iwb_v  = 1'b1;
      end
      7'b0110111, 7'b0010111, 7'b1101111: decode_o.iwb_v = 1'b1;
      7'b1100011: begin
        decode_o.irs1_v = 1'b1;
        decode_o.irs2_v = 1'b1;
      end
      7'b0000011, 7'b0101111: begin
        decode_o.irs1_v = 1'b1;
        decode_o.irs2_v = (opcode == 7'b0101111);
        decode_o.iwb_v  = 1'b1;
        decode_o.mem_v  = 1'b1;
      end
      7'b0100011: begin
        decode_o.irs1_v = 1'b1;
        decode_o.irs2_v = 1'b1;
        decode_o.mem_v  = 1'b1;
      end
      7'b0000111: begin
        decode_o.irs1_v = 1'b1;
        decode_o.fwb_v  = 1'b1;
        decode_o.mem_v  = 1'b1;
      end
      7'b0100111: begin
        decode_o.irs1_v = 1'b1;
        decode_o.frs2_v = 1'b1;
        decode_o.mem_v  = 1'b1;
      end
      7'b0001111: decode_o.fence_v = 1'b1;
      7'b1110011: begin
        // CSRRW/CSRRWI always write; set/clear forms write only with a nonzero source.
        decode_o.iwb_v   = (funct3 != 3'b000);
        decode_o.irs1_v  = (funct3 != 3'b000) && !funct3[2];
        decode_o.csr_w_v = (funct3 != 3'b000) && ((funct3[1:0] == 2'b01) || (instr_i[19:15] != 5'd0));
      end
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
        decode_o.frs1_v = 1'b1;
        decode_o.frs2_v = 1'b1;
        decode_o.frs3_v = 1'b1;
        decode_o.fwb_v  = 1'b1;
        decode_o.long_v = 1'b1;
      end
      7'b1010011: begin
        case (funct5)
          5'b10100: begin
            decode_o.frs1_v = 1'b1;
            decode_o.frs2_v = 1'b1;
            decode_o.iwb_v  = 1'b1;
          end
          5'b11100, 5'b11000: begin
            decode_o.frs1_v = 1'b1;
            decode_o.iwb_v  = 1'b1;
          end
          5'b11010, 5'b11110: begin
            decode_o.irs1_v = 1'b1;
            decode_o.fwb_v  = 1'b1;
          end
          5'b01011, 5'b01000: begin
            decode_o.frs1_v = 1'b1;
            decode_o.fwb_v  = 1'b1;
            decode_o.long_v = (funct5 == 5'b01011);
          end
          default: begin
            decode_o.frs1_v = 1'b1;
            decode_o.frs2_v = 1'b1;
            decode_o.fwb_v  = 1'b1;
            decode_o.long_v = (funct5 == 5'b00011);
          end
        endcase
      end
      default: decode_o = decode_o;
    endcase
  end

endmodule

// File: rtl/bp_be_issue_queue.sv
// Backend issue queue: circular buffer with speculative read pointer and commit
// pointer so issued-but-uncommitted instructions can be replayed.
module bp_be_issue_queue
  import bp_be_pkg::*;
#(
  parameter bp_params_e  bp_params_p = e_bp_default_cfg,
  parameter int unsigned els_p       = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  bp_be_issue_queue_if.slave io
);

  localparam int unsigned idx_width_lp  = $clog2(els_p);
  localparam int unsigned ptr_width_lp  = idx_width_lp + 1;
  localparam bit          default_cfg_lp = (bp_params_p == e_bp_default_cfg);

  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] cptr_q, cptr_d;

  bp_be_issue_pkt_s mem_q [els_p];
  bp_be_issue_pkt_s enq_pkt;
  bp_be_predecode_s enq_decode;

  logic full, empty, ready, issue_v, enq, deq, inc;

  bp_be_issue_predecode predecode (
    .instr_i  (io.fe_queue_i.instr),
    .decode_o (enq_decode)
  );

  // Full is measured against the commit pointer: uncommitted entries stay resident for replay.
  assign full    = (wptr_q[idx_width_lp-1:0] == cptr_q[idx_width_lp-1:0])
                && (wptr_q[idx_width_lp] != cptr_q[idx_width_lp]);
  assign empty   = (rptr_q == wptr_q);
  assign ready   = !full && !io.clr_v_i && !io.roll_v_i;
  assign issue_v = !empty && !io.roll_v_i && !io.clr_v_i;
  assign enq     = io.fe_queue_v_i && ready;
  assign deq     = io.deq_v_i && issue_v;
  assign inc     = io.inc_v_i && (cptr_q != rptr_q);

  assign enq_pkt = '{pc:              io.fe_queue_i.pc,
                     instr:           io.fe_queue_i.instr,
                     branch_metadata: io.fe_queue_i.branch_metadata,
                     decode:          enq_decode};

  assign io.fe_queue_ready_o = ready;
  assign io.issue_pkt_v_o    = issue_v;
  assign io.issue_pkt_o      = mem_q[rptr_q[idx_width_lp-1:0]];
  assign io.isd_status_o     = gate_isd_status(io.issue_pkt_o.decode, issue_v);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    if (io.clr_v_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cptr_d = '0;
    end else if (io.roll_v_i) begin
      rptr_d = cptr_q;
    end else begin
      if (enq) wptr_d = wptr_q + ptr_width_lp'(1);
      if (deq) rptr_d = rptr_q + ptr_width_lp'(1);
      if (inc) cptr_d = cptr_q + ptr_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // Entry storage is deliberately unreset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (enq && !reset_i) mem_q[wptr_q[idx_width_lp-1:0]] <= enq_pkt;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (default_cfg_lp)
        else $error("bp_be_issue_queue: unsupported bp_params_p");
      assert (!(io.deq_v_i && empty))
        else $error("bp_be_issue_queue: deq_v_i with no valid head entry");
      assert (!(io.inc_v_i && (cptr_q == rptr_q)))
        else $error("bp_be_issue_queue: inc_v_i with commit pointer at read pointer");
    end
  end

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Directed scoreboard bench for bp_be_issue_queue: expected issue order is queued
// by the stimulus and checked by a monitor on every accepted dispatch.
module tb_bp_be_issue_queue;
  import bp_be_pkg::*;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] FMADD = 32'h2231_70C3;  // fmadd.d f1,f2,f3,f4
  localparam logic [31:0] LD    = 32'h0085_3283;  // ld x5,8(x10)

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  bp_be_issue_queue_if io();

  bp_be_issue_queue #(.bp_params_p(e_bp_default_cfg), .els_p(8)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .io      (io)
  );

  int checks = 0;
  int errors = 0;
  logic [vaddr_width_gp-1:0] exp_q[$];

  logic                      s_ready, s_v;
  logic [vaddr_width_gp-1:0] s_pc;
  bp_be_isd_status_s         s_stat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset_i && io.deq_v_i && io.issue_pkt_v_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got pc 0x%0h expected no issue", io.issue_pkt_o.pc);
        end else begin
          chk("issue_pc", 64'(io.issue_pkt_o.pc), 64'(exp_q.pop_front()));
        end
      end
    end
  endtask

  task automatic cycle(input logic fev, input logic [vaddr_width_gp-1:0] pc, input logic [31:0] instr,
                       input logic deq, input logic inc, input logic roll, input logic clr);
    io.fe_queue_v_i = fev;
    io.fe_queue_i   = '{pc: pc, instr: instr, branch_metadata: 16'(pc)};
    io.deq_v_i      = deq;
    io.inc_v_i      = inc;
    io.roll_v_i     = roll;
    io.clr_v_i      = clr;
    @(negedge clk);
    s_ready = io.fe_queue_ready_o;
    s_v     = io.issue_pkt_v_o;
    s_pc    = io.issue_pkt_o.pc;
    s_stat  = io.isd_status_o;
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [vaddr_width_gp-1:0] pc, input logic [31:0] instr);
    cycle(1'b1, pc, instr, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic idle();  cycle(1'b0, '0, NOP, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic deq_c(); cycle(1'b0, '0, NOP, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic inc_c(); cycle(1'b0, '0, NOP, 1'b0, 1'b1, 1'b0, 1'b0); endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset, with an enqueue attempt that must be ignored
    reset_i = 1'b1;
    cycle(1'b1, 39'h0999_9990, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    reset_i = 1'b0;
    idle();
    chk("reset_ready", 64'(s_ready), 64'd1);
    chk("reset_v", 64'(s_v), 64'd0);

    // Two-entry fill and drain
    exp_q.push_back(39'h0_8000_0000);
    exp_q.push_back(39'h0_8000_0004);
    enq(39'h0_8000_0000, NOP);
    chk("no_bypass_v", 64'(s_v), 64'd0);
    enq(39'h0_8000_0004, NOP);
    chk("visible_next_cycle", 64'(s_v), 64'd1);
    deq_c();
    chk("drain_pc0", 64'(s_pc), 64'h8000_0000);
    deq_c();
    chk("drain_pc1", 64'(s_pc), 64'h8000_0004);
    idle();
    chk("drain_empty_v", 64'(s_v), 64'd0);
    inc_c();
    inc_c();

    // Fill to capacity; the ninth enqueue is dropped
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(39'(32'h1000 + 4 * i));
      enq(39'(32'h1000 + 4 * i), NOP);
      chk("fill_ready", 64'(s_ready), 64'd1);
    end
    enq(39'h0_000D_EAD0, NOP);
    chk("ninth_ready", 64'(s_ready), 64'd0);
    for (int i = 0; i < 8; i++) deq_c();
    idle();
    chk("full_until_commit", 64'(s_ready), 64'd0);
    chk("ninth_dropped_v", 64'(s_v), 64'd0);
    for (int i = 0; i < 8; i++) inc_c();
    idle();
    chk("ready_after_commit", 64'(s_ready), 64'd1);

    // Replay: issue three, commit one, roll back
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(39'(32'h2000 + 4 * i));
      enq(39'(32'h2000 + 4 * i), NOP);
    end
    for (int i = 0; i < 3; i++) deq_c();
    inc_c();
    cycle(1'b0, '0, NOP, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("roll_v_gated", 64'(s_v), 64'd0);
    chk("roll_ready_gated", 64'(s_ready), 64'd0);
    idle();
    chk("replay_head_pc", 64'(s_pc), 64'h2004);
    chk("replay_head_v", 64'(s_v), 64'd1);
    exp_q.push_back(39'h2004);
    exp_q.push_back(39'h2008);
    deq_c();
    deq_c();
    idle();
    chk("replay_done_v", 64'(s_v), 64'd0);
    inc_c();
    inc_c();

    // Enqueue, dequeue and commit together
    exp_q.push_back(39'h6000);
    exp_q.push_back(39'h6004);
    exp_q.push_back(39'h6008);
    enq(39'h6000, NOP);
    cycle(1'b1, 39'h6004, NOP, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 39'h6008, NOP, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("concurrent_ready", 64'(s_ready), 64'd1);
    cycle(1'b0, '0, NOP, 1'b1, 1'b1, 1'b0, 1'b0);
    inc_c();
    idle();
    chk("concurrent_empty", 64'(s_v), 64'd0);

    // Twenty enq/deq/inc triples across pointer wraps
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(39'(32'h7000 + 4 * i));
      enq(39'(32'h7000 + 4 * i), NOP);
      chk("wrap_ready", 64'(s_ready), 64'd1);
      deq_c();
      chk("wrap_v", 64'(s_v), 64'd1);
      inc_c();
      chk("wrap_empty", 64'(s_v), 64'd0);
    end

    // Clear beats roll, dequeue and enqueue in the same cycle
    enq(39'h3000, NOP);
    enq(39'h3004, NOP);
    cycle(1'b1, 39'h3008, NOP, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("clr_ready_gated", 64'(s_ready), 64'd0);
    chk("clr_v_gated", 64'(s_v), 64'd0);
    idle();
    chk("clr_empty_v", 64'(s_v), 64'd0);
    chk("clr_ready", 64'(s_ready), 64'd1);
    exp_q.push_back(39'h4000);
    enq(39'h4000, NOP);
    deq_c();
    chk("post_clr_pc", 64'(s_pc), 64'h4000);
    idle();
    chk("post_clr_single", 64'(s_v), 64'd0);
    inc_c();

    // Reset mid-operation acts as a clear
    enq(39'h3100, NOP);
    reset_i = 1'b1;
    cycle(1'b1, 39'h3104, NOP, 1'b1, 1'b0, 1'b0, 1'b0);
    reset_i = 1'b0;
    idle();
    chk("midreset_v", 64'(s_v), 64'd0);
    chk("midreset_ready", 64'(s_ready), 64'd1);

    // Pre-decode of an FP fused multiply-add and an integer load
    exp_q.push_back(39'h5000);
    enq(39'h5000, FMADD);
    idle();
    chk("fmadd_frs1_v", 64'(s_stat.decode.frs1_v), 64'd1);
    chk("fmadd_frs2_v", 64'(s_stat.decode.frs2_v), 64'd1);
    chk("fmadd_frs3_v", 64'(s_stat.decode.frs3_v), 64'd1);
    chk("fmadd_fwb_v", 64'(s_stat.decode.fwb_v), 64'd1);
    chk("fmadd_irs1_v", 64'(s_stat.decode.irs1_v), 64'd0);
    chk("fmadd_rs3_addr", 64'(s_stat.decode.rs3_addr), 64'd4);
    chk("fmadd_rs1_addr", 64'(s_stat.decode.rs1_addr), 64'd2);
    chk("fmadd_rd_addr", 64'(s_stat.decode.rd_addr), 64'd1);
    cycle(1'b0, '0, NOP, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("status_gated_fwb", 64'(s_stat.decode.fwb_v), 64'd0);
    chk("status_gated_v", 64'(s_stat.v), 64'd0);
    deq_c();
    inc_c();
    exp_q.push_back(39'h5004);
    enq(39'h5004, LD);
    idle();
    chk("ld_mem_v", 64'(s_stat.decode.mem_v), 64'd1);
    chk("ld_irs1_v", 64'(s_stat.decode.irs1_v), 64'd1);
    chk("ld_iwb_v", 64'(s_stat.decode.iwb_v), 64'd1);
    chk("ld_fwb_v", 64'(s_stat.decode.fwb_v), 64'd0);
    chk("ld_rd_addr", 64'(s_stat.decode.rd_addr), 64'd5);
    deq_c();
    inc_c();

    idle();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
